// File: rtl/fifo_word_unpacker_if.sv
// ---------------------------------------------------------------------------
// fifo_word_unpacker_if
//   Bundles the word-side handshake and the FIFO write-port signals of
//   fifo_word_unpacker so the block can be dropped in front of the 16x8 sync
//   FIFO with a single connection.
//
//   Signals
//     in_data  [8*BYTES_PER_WORD-1:0]  input word, byte i = in_data[8*i+7:8*i]
//     in_keep  [BYTES_PER_WORD-1:0]    byte-enable mask, bit i=1 -> byte i kept
//     in_valid                         upstream word valid
//     in_ready                         unpacker can take a word this cycle
//     full                             FIFO full flag
//     wr                               FIFO write strobe
//     din      [DW-1:0]                FIFO write data
//     busy                             a word is currently held
//
//   Modports
//     slave  : the unpacker itself
//     master : the environment (upstream source plus the FIFO status side)
// ---------------------------------------------------------------------------
interface fifo_word_unpacker_if #(
  parameter int BYTES_PER_WORD = 4,
  parameter int DW             = 8
);
  logic [BYTES_PER_WORD*DW-1:0] in_data;
  logic [BYTES_PER_WORD-1:0]    in_keep;
  logic                         in_valid;
  logic                         in_ready;
  logic                         full;
  logic                         wr;
  logic [DW-1:0]                din;
  logic                         busy;

  modport slave (
    input  in_data, in_keep, in_valid, full,
    output in_ready, wr, din, busy
  );

  modport master (
    output in_data, in_keep, in_valid, full,
    input  in_ready, wr, din, busy
  );
endinterface

// File: rtl/fifo_word_unpacker.sv
// ---------------------------------------------------------------------------
// fifo_word_unpacker
//   Write-side feeder for the 16x8 sync FIFO. Takes BYTES_PER_WORD-byte words
//   with a byte-keep mask on a valid/ready handshake and emits the kept bytes
//   one per cycle onto the FIFO write port, throttled by the FIFO full flag.
//   Sustains one byte per cycle across back-to-back words with no bubble.
//
//   Ports
//     clk  : single clock, all logic on posedge
//     rst  : synchronous, active-high reset
//     bus  : fifo_word_unpacker_if.slave (in_data/in_keep/in_valid/in_ready,
//            full, wr/din, busy)
//
//   Configuration macro
//     UNPACK_MSB_FIRST_EN : when defined, the highest kept byte is emitted
//                           first; otherwise the lowest kept byte goes first.
//                           Handshake and timing are the same either way.
// ---------------------------------------------------------------------------
module fifo_word_unpacker #(
  parameter int BYTES_PER_WORD = 4,
  parameter int DW             = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_word_unpacker_if.slave  bus
);

  localparam int SW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [BYTES_PER_WORD*DW-1:0]  hold_data_q, hold_data_d;
  logic [BYTES_PER_WORD-1:0]     hold_keep_q, hold_keep_d;
  logic [DW-1:0]                 din_hold_q, din_hold_d;

  logic [DW-1:0]                 byte_arr [BYTES_PER_WORD];
  logic [SW-1:0]                 sel;
  logic [DW-1:0]                 sel_byte;
  logic [BYTES_PER_WORD-1:0]     keep_clr;
  logic                          last;
  logic                          accept;

  logic                          wr_w;
  logic                          in_ready_w;
  logic                          busy_w;
  logic [DW-1:0]                 din_w;

  // Slice the held word into bytes so the selected byte is a plain mux.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_bytes
    assign byte_arr[gi] = hold_data_q[gi*DW +: DW];
  end

  // Priority pick of the next byte to emit. The loop runs in the opposite
  // direction of the priority so the last hit wins.
  always_comb begin
    sel = '0;
`ifdef UNPACK_MSB_FIRST_EN
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (hold_keep_q[i]) sel = SW'(i);
    end
`else
    for (int i = BYTES_PER_WORD - 1; i >= 0; i--) begin
      if (hold_keep_q[i]) sel = SW'(i);
    end
`endif
  end

  assign sel_byte = byte_arr[sel];
  assign keep_clr = hold_keep_q & ~(BYTES_PER_WORD'(1) << sel);
  // In SEND the mask is never empty, so "nothing left after clearing sel"
  // is the same as "exactly one bit set".
  assign last     = (keep_clr == '0);
  assign accept   = bus.in_valid & in_ready_w;

  // State register. Reset drops any partially sent word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      din_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      din_hold_q  <= din_hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    din_hold_d  = din_hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_data_d = bus.in_data;
          hold_keep_d = bus.in_keep;
          // An all-zero mask is swallowed without ever leaving IDLE.
          state_d     = (bus.in_keep != '0) ? SEND : IDLE;
        end
      end
      SEND: begin
        if (wr_w) begin
          din_hold_d  = sel_byte;
          hold_keep_d = keep_clr;
          if (last) begin
            // accept can only be true here (in_ready = wr & last), so the
            // next word is loaded on the same edge the final byte goes out.
            if (accept) begin
              hold_data_d = bus.in_data;
              hold_keep_d = bus.in_keep;
              state_d     = (bus.in_keep != '0) ? SEND : IDLE;
            end else begin
              state_d     = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    wr_w       = 1'b0;
    in_ready_w = 1'b0;
    busy_w     = 1'b0;
    din_w      = din_hold_q;
    case (state_q)
      IDLE: begin
        in_ready_w = 1'b1;
      end
      SEND: begin
        busy_w     = 1'b1;
        // Strobe only when the FIFO has room, so every strobe is committed.
        wr_w       = ~bus.full & ~rst;
        din_w      = sel_byte;
        in_ready_w = wr_w & last;
      end
      default: ;
    endcase
  end

  assign bus.wr       = wr_w;
  assign bus.in_ready = in_ready_w;
  assign bus.busy     = busy_w;
  assign bus.din      = din_w;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// ---------------------------------------------------------------------------
// tb_fifo_word_unpacker
//   Directed bench for fifo_word_unpacker. Inputs change 1ns after each rising
//   edge; outputs are checked on the following falling edge against
//   hand-computed values. Honours UNPACK_MSB_FIRST_EN for the expected byte
//   order.
// ---------------------------------------------------------------------------
module tb_fifo_word_unpacker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_word_unpacker_if #(.BYTES_PER_WORD(4), .DW(8)) bus ();

  fifo_word_unpacker #(.BYTES_PER_WORD(4), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] W1  = 32'hDDCCBBAA;
  localparam logic [31:0] W2  = 32'h44332211;
  localparam logic [31:0] W4A = 32'h03020100;
  localparam logic [31:0] W4B = 32'h07060504;
`ifdef UNPACK_MSB_FIRST_EN
  localparam logic [7:0] T2_FIRST  = 8'h33;
  localparam logic [7:0] T2_SECOND = 8'h11;
`else
  localparam logic [7:0] T2_FIRST  = 8'h11;
  localparam logic [7:0] T2_SECOND = 8'h33;
`endif

  // n-th byte emitted from a fully kept word.
  function automatic logic [7:0] bt(input logic [31:0] w, input int n);
    int i;
`ifdef UNPACK_MSB_FIRST_EN
    i = 3 - n;
`else
    i = n;
`endif
    return w[8*i +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eo(input string tag, input logic e_wr, input logic [7:0] e_din,
                    input logic e_rdy, input logic e_busy, input logic chk_din);
    chk({tag, ".wr"}, {31'd0, bus.wr}, {31'd0, e_wr});
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, e_rdy});
    chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, e_busy});
    if (chk_din) chk({tag, ".din"}, {24'd0, bus.din}, {24'd0, e_din});
    $display("[%0t] %s wr=%b din=%h in_ready=%b busy=%b", $time, tag,
             bus.wr, bus.din, bus.in_ready, bus.busy);
  endtask

  task automatic cyc(input logic r, input logic v, input logic [31:0] d,
                     input logic [3:0] k, input logic f);
    @(posedge clk);
    #1;
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.full     = f;
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_keep  = '0;
    bus.full     = 1'b0;

    // Reset with a valid word presented: it must not be taken.
    cyc(1'b1, 1'b1, W1, 4'hF, 1'b0);
    chk("rst0.wr", {31'd0, bus.wr}, 32'd0);
    cyc(1'b1, 1'b1, W1, 4'hF, 1'b0);
    chk("rst1.wr", {31'd0, bus.wr}, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
    eo("reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Test 1: full word, four bytes in order.
    cyc(1'b0, 1'b1, W1, 4'hF, 1'b0);
    eo("t1_accept", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
      eo($sformatf("t1_b%0d", n), 1'b1, bt(W1, n), (n == 3), 1'b1, 1'b1);
    end
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
    eo("t1_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Test 2: sparse mask, two writes.
    cyc(1'b0, 1'b1, W2, 4'b0101, 1'b0);
    eo("t2_accept", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
    eo("t2_b0", 1'b1, T2_FIRST, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
    eo("t2_b1", 1'b1, T2_SECOND, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
    eo("t2_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Test 3: FIFO full for three cycles after the second byte.
    cyc(1'b0, 1'b1, W1, 4'hF, 1'b0);
    eo("t3_accept", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
      eo($sformatf("t3_b%0d", n), 1'b1, bt(W1, n), 1'b0, 1'b1, 1'b1);
    end
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b1);
      eo($sformatf("t3_full%0d", n), 1'b0, bt(W1, 2), 1'b0, 1'b1, 1'b1);
    end
    for (int n = 2; n < 4; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
      eo($sformatf("t3_b%0d", n), 1'b1, bt(W1, n), (n == 3), 1'b1, 1'b1);
    end
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
    eo("t3_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Test 4: back-to-back words with in_valid held high.
    cyc(1'b0, 1'b1, W4A, 4'hF, 1'b0);
    eo("t4_accept", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 1'b1, W4B, 4'hF, 1'b0);
      eo($sformatf("t4_a%0d", n), 1'b1, bt(W4A, n), (n == 3), 1'b1, 1'b1);
    end
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
      eo($sformatf("t4_b%0d", n), 1'b1, bt(W4B, n), (n == 3), 1'b1, 1'b1);
    end
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
    eo("t4_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Test 5: empty keep mask is swallowed.
    cyc(1'b0, 1'b1, 32'hCAFEF00D, 4'h0, 1'b0);
    eo("t5_accept", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
      eo($sformatf("t5_after%0d", n), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // Test 6: reset in the middle of a word.
    cyc(1'b0, 1'b1, W1, 4'hF, 1'b0);
    eo("t6_accept", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
      eo($sformatf("t6_b%0d", n), 1'b1, bt(W1, n), 1'b0, 1'b1, 1'b1);
    end
    cyc(1'b1, 1'b0, 32'd0, 4'h0, 1'b0);
    chk("t6_rst.wr", {31'd0, bus.wr}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, 1'b0, 32'd0, 4'h0, 1'b0);
      eo($sformatf("t6_post%0d", n), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
